// File: rtl/prim_ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prim_ram_pkg : shared types and helpers for the single-port RAM primitive
// Rev 1.0
// ----------------------------------------------------------------------------
package prim_ram_pkg;

  typedef enum logic [0:0] {
    RamInit  = 1'b0,
    RamReady = 1'b1
  } ram_state_e;

  function automatic int unsigned mask_groups(input int unsigned width,
                                              input int unsigned bits_per_mask);
    return width / bits_per_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prim_ram_1p_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prim_ram_1p_pipe : single-port RAM with req/gnt, read-valid strobe,
//                    optional output register and zero sweep after reset
// Rev 1.0
// ----------------------------------------------------------------------------
module prim_ram_1p_pipe
  import prim_ram_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 128,
  parameter int unsigned DataBitsPerMask = 1,
  parameter bit          OutputReg       = 1'b0,
  parameter bit          InitOnReset     = 1'b1,
  localparam int unsigned Aw             = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             init_done_o
);

  localparam int unsigned   NumGroups = mask_groups(Width, DataBitsPerMask);
  localparam logic [Aw:0]   DepthExt  = (Aw+1)'(Depth);
  localparam logic [Aw-1:0] LastAddr  = Aw'(Depth - 1);

  ram_state_e           state_q, state_d;
  logic [Aw-1:0]        init_cnt_q, init_cnt_d;
  logic                 in_range;
  logic                 gnt;
  logic                 mem_we;
  logic [Aw-1:0]        mem_addr;
  logic [Width-1:0]     mem_wdata;
  logic [NumGroups-1:0] req_grp_en;
  logic [NumGroups-1:0] mem_grp_en;
  logic                 rvalid_q, rvalid_d;
  logic [Width-1:0]     rdata_q, rdata_d;
  logic [Width-1:0]     mem [Depth];

  assign in_range    = {1'b0, addr_i} < DepthExt;
  assign gnt         = req_i && (state_q == RamReady);
  assign gnt_o       = gnt;
  assign init_done_o = (state_q == RamReady);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      RamInit: begin
        init_cnt_d = init_cnt_q + Aw'(1);
        if (init_cnt_q == LastAddr) begin
          state_d    = RamReady;
          init_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= InitOnReset ? RamInit : RamReady;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // A group is written only when every bit of its mask slice is set.
  for (genvar k = 0; k < NumGroups; k++) begin : g_mask_reduce
    assign req_grp_en[k] = &wmask_i[k*DataBitsPerMask +: DataBitsPerMask];
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = addr_i;
    mem_wdata  = wdata_i;
    mem_grp_en = req_grp_en;
    if (state_q == RamInit) begin
      mem_we     = 1'b1;
      mem_addr   = init_cnt_q;
      mem_wdata  = '0;
      mem_grp_en = '1;
    end else if (gnt && write_i && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < NumGroups; k++) begin
        if (mem_grp_en[k]) begin
          mem[mem_addr][k*DataBitsPerMask +: DataBitsPerMask] <=
            mem_wdata[k*DataBitsPerMask +: DataBitsPerMask];
        end
      end
    end
  end

  // Read data is held between reads; out-of-range reads return zero.
  always_comb begin
    rvalid_d = gnt && !write_i;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = in_range ? mem[addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  if (OutputReg) begin : g_out_reg
    logic             pipe_rvalid_q;
    logic [Width-1:0] pipe_rdata_q, pipe_rdata_d;

    always_comb begin
      pipe_rdata_d = rvalid_q ? rdata_q : pipe_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_rvalid_q <= 1'b0;
        pipe_rdata_q  <= '0;
      end else begin
        pipe_rvalid_q <= rvalid_q;
        pipe_rdata_q  <= pipe_rdata_d;
      end
    end

    assign rvalid_o = pipe_rvalid_q;
    assign rdata_o  = pipe_rdata_q;
  end else begin : g_no_out_reg
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_1p_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prim_ram_1p_pipe : three RAM configurations driven by shared directed
//                       stimulus, checked against a word-level memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_prim_ram_1p_pipe;

  localparam int N = 3;  // 0: D128 mask8 lat1, 1: D100 mask1 lat2, 2: D128 no-init lat1

  int dep [N] = '{128, 100, 128};
  int dbm [N] = '{8, 1, 1};
  int lat [N] = '{1, 2, 1};
  bit ini [N] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] wmask = '0;

  logic [N-1:0] gnt, rv, idn;
  logic [31:0]  rd [N];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prim_ram_1p_pipe #(.Width(32), .Depth(128), .DataBitsPerMask(8),
                     .OutputReg(1'b0), .InitOnReset(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt[0]), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rv[0]),
    .rdata_o(rd[0]), .init_done_o(idn[0]));

  prim_ram_1p_pipe #(.Width(32), .Depth(100), .DataBitsPerMask(1),
                     .OutputReg(1'b1), .InitOnReset(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt[1]), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rv[1]),
    .rdata_o(rd[1]), .init_done_o(idn[1]));

  prim_ram_1p_pipe #(.Width(32), .Depth(128), .DataBitsPerMask(1),
                     .OutputReg(1'b0), .InitOnReset(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt[2]), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rv[2]),
    .rdata_o(rd[2]), .init_done_o(idn[2]));

  // ---------------- model ----------------
  logic [31:0] mmem   [N][128];
  bit          mknown [N][128];
  int          since  [N];
  int          cyc = 100;
  int          due    [N][4];
  logic [31:0] dued   [N][4];
  bit          duek   [N][4];
  logic [31:0] erd    [N];
  bit          erk    [N];

  function automatic bit rdy(input int i);
    return !ini[i] || (since[i] >= dep[i]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] m, input int d);
    logic [31:0] r;
    logic [31:0] gm;
    r = old;
    for (int g = 0; g < 32 / d; g++) begin
      gm = ((32'h1 << d) - 32'h1) << (g * d);
      if ((m & gm) == gm) r = (r & ~gm) | (nw & gm);
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        since[i] <= 0;
        for (int s = 0; s < 4; s++) due[i][s] <= -1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        since[i] <= since[i] + 1;
        if (!rdy(i)) begin
          mmem[i][since[i]]   <= '0;
          mknown[i][since[i]] <= 1'b1;
        end else if (req && write) begin
          if (int'(addr) < dep[i]) begin
            mmem[i][addr]   <= merge(mmem[i][addr], wdata, wmask, dbm[i]);
            mknown[i][addr] <= mknown[i][addr] ||
                               (merge(32'h0, 32'hFFFF_FFFF, wmask, dbm[i]) == 32'hFFFF_FFFF);
          end
        end else if (req) begin
          due[i][(cyc + lat[i]) % 4]  <= cyc + lat[i];
          dued[i][(cyc + lat[i]) % 4] <= (int'(addr) < dep[i]) ? mmem[i][addr] : 32'h0;
          duek[i][(cyc + lat[i]) % 4] <= (int'(addr) >= dep[i]) || mknown[i][addr];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bit          ev;
        logic [31:0] ed;
        bit          ek;
        ev = 1'b0;
        ed = '0;
        ek = 1'b0;
        for (int s = 0; s < 4; s++) begin
          if (due[i][s] == cyc) begin
            ev = 1'b1;
            ed = dued[i][s];
            ek = duek[i][s];
          end
        end
        if (!rst_n) begin
          erd[i] = '0;
          erk[i] = 1'b1;
        end else if (ev) begin
          erd[i] = ed;
          erk[i] = ek;
        end
        chk($sformatf("i%0d init_done", i), 32'(idn[i]), 32'(rdy(i)));
        if (rst_n) chk($sformatf("i%0d gnt", i), 32'(gnt[i]), 32'(req && rdy(i)));
        chk($sformatf("i%0d rvalid", i), 32'(rv[i]), 32'(ev));
        if (erk[i]) chk($sformatf("i%0d rdata", i), rd[i], erd[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input bit w, input int a, input logic [31:0] d, input logic [31:0] m);
    @(posedge clk);
    #2;
    req   = 1'b1;
    write = w;
    addr  = 7'(a);
    wdata = d;
    wmask = m;
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    req   = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    req = 1'b1; write = 1'b0; addr = 7'd5;
    @(negedge clk);
    chk("reset a init_done", 32'(idn[0]), 32'h0);
    chk("reset a gnt", 32'(gnt[0]), 32'h0);
    chk("reset a rvalid", 32'(rv[0]), 32'h0);
    chk("reset a rdata", rd[0], 32'h0);
    chk("reset c init_done", 32'(idn[2]), 32'h1);
    @(posedge clk); #2 rst_n = 1'b1;

    repeat (127) @(posedge clk);
    @(negedge clk);
    chk("sweep127 a init_done", 32'(idn[0]), 32'h0);
    chk("sweep127 a gnt", 32'(gnt[0]), 32'h0);
    @(negedge clk);
    chk("sweep128 a init_done", 32'(idn[0]), 32'h1);
    chk("sweep128 a gnt", 32'(gnt[0]), 32'h1);
    @(negedge clk);
    chk("addr5 a rvalid", 32'(rv[0]), 32'h1);
    chk("addr5 a rdata", rd[0], 32'h0);

    // write then read same address
    op(1, 3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    op(0, 3, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    chk("raw a rvalid", 32'(rv[0]), 32'h1);
    chk("raw a rdata", rd[0], 32'hDEAD_BEEF);
    chk("raw b rvalid early", 32'(rv[1]), 32'h0);
    @(negedge clk);
    chk("raw b rvalid", 32'(rv[1]), 32'h1);
    chk("raw b rdata", rd[1], 32'hDEAD_BEEF);
    chk("raw a hold", rd[0], 32'hDEAD_BEEF);

    // partial masks
    op(1, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(1, 7, 32'h0, 32'h00FF_00F0);
    op(0, 7, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    chk("mask a byte", rd[0], 32'hFF00_FFFF);
    chk("mask c bit", rd[2], 32'hFF00_FF0F);
    @(negedge clk);
    chk("mask b bit", rd[1], 32'hFF00_FF0F);
    op(1, 8, 32'h1234_ABCD, 32'hFFFF_FFFF);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("write keeps a rdata", rd[0], 32'hFF00_FFFF);

    // back-to-back reads
    for (int k = 0; k < 3; k++) op(1, k, 32'h10 + 32'(k), 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) op(0, k, 32'h0, 32'h0);
      else idle();
      if (k > 0) begin
        @(negedge clk);
        chk("b2b a rvalid", 32'(rv[0]), 32'h1);
        chk("b2b a rdata", rd[0], 32'h10 + 32'(k - 1));
      end
    end

    // out-of-range on the 100-deep instance
    op(1, 100, 32'h1234, 32'hFFFF_FFFF);
    op(0, 100, 32'h0, 32'h0);
    op(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("oor a rdata", rd[0], 32'h1234);
    idle();
    @(negedge clk);
    chk("oor a addr0", rd[0], 32'h10);
    chk("oor b rvalid", 32'(rv[1]), 32'h1);
    chk("oor b rdata", rd[1], 32'h0);
    @(negedge clk);
    chk("oor b addr0", rd[1], 32'h10);

    // mixed traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else op(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), $urandom(),
              ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom());
    end
    idle();
    repeat (4) @(negedge clk);

    // reset in the middle of the sweep
    op(1, 99, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    op(0, 99, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    chk("pre-reset a addr99", rd[0], 32'hA5A5_A5A5);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst a rdata", rd[0], 32'h0);
    chk("rst a init_done", 32'(idn[0]), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (127) @(posedge clk);
    @(negedge clk);
    chk("resweep127 a init_done", 32'(idn[0]), 32'h0);
    @(negedge clk);
    chk("resweep128 a init_done", 32'(idn[0]), 32'h1);
    op(0, 99, 32'h0, 32'h0);
    idle();
    @(negedge clk);
    chk("resweep a addr99", rd[0], 32'h0);
    chk("no-init c addr99", rd[2], 32'hA5A5_A5A5);
    @(negedge clk);
    chk("resweep b addr99", rd[1], 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prim_ram_1p_pipe.md
# prim_ram_1p_pipe

Parametrised single-port synchronous RAM with a request/grant handshake, read-valid strobe, optional output pipeline register and hardware zeroisation after reset. It serves as the generic storage primitive behind register files, instruction caches and scratchpads. Clients must not issue requests until `init_done_o` is high.

## Interface
Parameters:
- `Width`, 32, data word width in bits.
- `Depth`, 128, number of words; need not be a power of two.
- `DataBitsPerMask`, 1, bits per write-mask group; `Width` must be a multiple of it.
- `OutputReg`, 0, 1 adds a registered output stage (read latency 2 instead of 1).
- `InitOnReset`, 1, 1 zeroes every word after reset; 0 skips the sweep.
- `Aw`, derived localparam, `$clog2(Depth)`.

Ports:
- `clk_i` input, 1, clock; all state changes on the rising edge.
- `rst_ni` input, 1, asynchronous active-low reset.
- `req_i` input, 1, access request.
- `gnt_o` output, 1, request accepted this cycle.
- `write_i` input, 1, 1 = write, 0 = read; sampled when `gnt_o` is high.
- `addr_i` input, Aw, word address.
- `wdata_i` input, Width, write data.
- `wmask_i` input, Width, per-bit write enable.
- `rvalid_o` output, 1, one-cycle strobe; `rdata_o` is valid.
- `rdata_o` output, Width, read data.
- `init_done_o` output, 1, zeroisation complete.

## Operation
- FSM states: INIT and READY.
  - Reset enters INIT when `InitOnReset`=1, otherwise READY.
  - INIT writes zero to address `init_cnt` each cycle; `init_cnt` counts 0..Depth-1.
  - At `Depth-1` the FSM moves to READY and `init_cnt` is no longer used.
- `gnt_o` = `req_i` AND state==READY. It is combinational and never asserts in INIT.
- Write, on grant with `write_i`=1:
  - Mask group k is enabled only when all of `wmask_i[k*DataBitsPerMask +: DataBitsPerMask]` are 1.
  - Only enabled groups of `mem[addr_i]` are updated.
  - A write produces no `rvalid_o`.
- Read, on grant with `write_i`=0: `mem[addr_i]` is returned with `rvalid_o` after the read latency.
- `rdata_o` holds the last read value until the next read completes. Writes never disturb it.
- Out-of-range address (`addr_i` >= Depth):
  - A write is dropped.
  - A read still gets grant and `rvalid_o`, with `rdata_o` = 0.
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, and the pipeline stage is 0.
  - `init_done_o` = 0 when `InitOnReset`=1, and 1 otherwise.
- Reset asserted mid-sweep aborts the sweep. After release the sweep restarts from address 0.
- Reset does not clear the memory array itself; only the sweep does.

## Timing
- Read latency, grant edge to `rvalid_o`: 1 cycle when `OutputReg`=0, 2 cycles when `OutputReg`=1.
- Fully pipelined: one grant per cycle, including back-to-back reads and read/write interleaving.
- Read-after-write to the same address in the following cycle returns the new data. Only one operation exists per cycle, so there are no collisions.
- Sweep timing: the first zero is written on the first rising edge after `rst_ni` rises. `init_done_o` goes high after edge `Depth`, i.e. cycle 128 for the default depth.
- `rvalid_o` never asserts in the same cycle as grant.

## Structure
- Shared package `prim_ram_pkg` holds:
  - `ram_state_e` enum (`RamInit`, `RamReady`);
  - a mask-group count helper function `(Width / DataBitsPerMask)`.
- No sub-module. Storage, mask reduction, init counter and output pipeline live in this module.
- The init path muxes into the write port with an all-ones mask and zero data.

## Test plan
- Reset with Depth=128, InitOnReset=1, `req_i` held high:
  - `gnt_o` stays 0 for 128 cycles and `init_done_o` rises after edge 128.
  - A read of addr 5 then returns 0.
- Write 0xDEADBEEF to addr 3, then read addr 3 next cycle:
  - `rvalid_o` 1 cycle later with 0xDEADBEEF.
  - With `OutputReg`=1 this arrives 2 cycles later.
- DataBitsPerMask=8, write 0xFFFFFFFF, then write 0x00000000 with `wmask_i`=0x00FF00F0:
  - Read returns 0xFF00FFFF; the partially masked low byte is untouched.
- Reads of addrs 0,1,2 on consecutive cycles after writing 0x10,0x11,0x12:
  - `rvalid_o` high for 3 consecutive cycles with data 0x10,0x11,0x12.
- Depth=100, write 0x1234 to addr 100, then read addr 100:
  - `rdata_o`=0 and addr 0 is unchanged.
- Assert `rst_ni` at sweep cycle 50 after first writing nonzero data to addr 99:
  - After release the sweep restarts and `init_done_o` rises after edge 128.
  - Addr 99 reads 0.
